// File: rtl/wb_ifetch_if.sv
// Wishbone classic-pipelined bundle between the fetch master
// and the program ROM slave; 16-bit data, word addressed.
interface if_wb #(
   parameter int aw = 13
) (
   input logic clk,
   input logic rst
);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [1:0]    sel;
   logic [aw-1:0] adr;
   logic [15:0]   dat_i;
   logic          ack;
   logic          stall;

   modport master (
      input  clk, rst, dat_i, ack, stall,
      output cyc, stb, we, sel, adr
   );

   modport slave (
      input  clk, rst, cyc, stb, we, sel, adr,
      output dat_i, ack, stall
   );
endinterface

// File: rtl/wb_ifetch.sv
// J1 instruction prefetch: streams sequential ROM words over
// pipelined Wishbone into a small FIFO, flushed on pc_load.
module wb_ifetch #(
   parameter int size     = 'h2000,
   parameter int depth    = 4,
   parameter int reset_pc = 0
) (
   if_wb.master                   wb,
   input  logic                   pc_load,
   input  logic [$clog2(size)-1:0] pc_target,
   output logic [15:0]            insn,
   output logic [$clog2(size)-1:0] insn_pc,
   output logic                   insn_valid,
   input  logic                   insn_ready
);
   localparam int aw = $clog2(size);
   localparam int pw = $clog2(depth);
   localparam int cw = pw + 1;
   localparam logic [cw:0] full = (cw+1)'(depth);

   logic [aw-1:0] fa;
   logic [aw-1:0] ra;
   logic [cw-1:0] out_cnt;
   logic [cw-1:0] dis_cnt;
   logic [cw-1:0] cnt;
   logic [cw-1:0] out_nxt;
   logic [pw-1:0] rd_ptr;
   logic [pw-1:0] wr_ptr;
   logic          run;
   logic [15:0]   mem_d  [depth];
   logic [aw-1:0] mem_pc [depth];

   logic          stb;
   logic          accept;
   logic          ack;
   logic          keep;
   logic          pop;
   logic [cw:0]   credit;

   // stb waits one cycle after reset so the bus stays idle
   // while the core is still held in reset
   always_comb begin
      credit  = {1'b0, cnt} + {1'b0, out_cnt};
      stb     = run & (credit < full) & (dis_cnt == '0);
      accept  = stb & ~wb.stall;
      ack     = wb.ack & (out_cnt != '0);
      keep    = ack & (dis_cnt == '0) & ~pc_load;
      pop     = insn_valid & insn_ready & ~pc_load;
      out_nxt = out_cnt + cw'(accept) - cw'(ack);
   end

   always_ff @(posedge wb.clk) begin
      if (wb.rst) begin
         fa      <= aw'(reset_pc);
         ra      <= aw'(reset_pc);
         out_cnt <= '0;
         dis_cnt <= '0;
         cnt     <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         run     <= 1'b0;
      end else begin
         run     <= 1'b1;
         out_cnt <= out_nxt;
         if (pc_load) begin
            fa      <= pc_target;
            ra      <= pc_target;
            dis_cnt <= out_nxt;
            cnt     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
         end else begin
            if (accept)
               fa <= fa + 1'b1;
            if (ack && dis_cnt != '0)
               dis_cnt <= dis_cnt - 1'b1;
            if (keep) begin
               wr_ptr <= wr_ptr + 1'b1;
               ra     <= ra + 1'b1;
            end
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + cw'(keep) - cw'(pop);
         end
      end
   end

   always_ff @(posedge wb.clk) begin
      if (keep) begin
         mem_d[wr_ptr]  <= wb.dat_i;
         mem_pc[wr_ptr] <= ra;
      end
   end

   assign wb.cyc     = stb | (out_cnt != '0);
   assign wb.stb     = stb;
   assign wb.we      = 1'b0;
   assign wb.sel     = 2'b11;
   assign wb.adr     = fa;
   assign insn       = mem_d[rd_ptr];
   assign insn_pc    = mem_pc[rd_ptr];
   assign insn_valid = cnt != '0;
endmodule

// File: tb/tb_wb_ifetch.sv
// Self-checking bench for wb_ifetch with a queued ROM slave
// model; rom[i] = i ^ 16'hA5A5.
module tb_wb_ifetch;
   localparam int aw = 13;

   logic clk = 1'b0;
   logic rst;
   logic rst2;
   always #5 clk = ~clk;

   if_wb #(.aw(aw)) bus  (.clk(clk), .rst(rst));
   if_wb #(.aw(aw)) bus2 (.clk(clk), .rst(rst2));

   logic          pc_load;
   logic [aw-1:0] pc_target;
   logic [15:0]   insn;
   logic [aw-1:0] insn_pc;
   logic          insn_valid;
   logic          ready;

   logic          pc_load2;
   logic [aw-1:0] pc_target2;
   logic [15:0]   insn2;
   logic [aw-1:0] insn_pc2;
   logic          insn_valid2;
   logic          ready2;

   wb_ifetch #(
      .size('h2000), .depth(4), .reset_pc(0)
   ) u_dut (
      .wb(bus),
      .pc_load(pc_load),
      .pc_target(pc_target),
      .insn(insn),
      .insn_pc(insn_pc),
      .insn_valid(insn_valid),
      .insn_ready(ready)
   );

   wb_ifetch #(
      .size('h2000), .depth(4), .reset_pc('h1FFE)
   ) u_wrap (
      .wb(bus2),
      .pc_load(pc_load2),
      .pc_target(pc_target2),
      .insn(insn2),
      .insn_pc(insn_pc2),
      .insn_valid(insn_valid2),
      .insn_ready(ready2)
   );

   function automatic logic [15:0] rom(input logic [aw-1:0] a);
      return {3'b000, a} ^ 16'hA5A5;
   endfunction

   // ROM slaves: requests queue up, acked in order when
   // ack_en is set; dropping cyc aborts the queue
   logic          ack_en;
   logic [aw-1:0] q1[$];
   logic [aw-1:0] q2[$];

   always @(posedge clk) begin
      bus.ack <= 1'b0;
      if (!bus.cyc) begin
         q1.delete();
      end else begin
         if (bus.stb && !bus.stall)
            q1.push_back(bus.adr);
         if (ack_en && q1.size() != 0) begin
            bus.dat_i <= rom(q1[0]);
            bus.ack   <= 1'b1;
            void'(q1.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      bus2.ack <= 1'b0;
      if (!bus2.cyc) begin
         q2.delete();
      end else begin
         if (bus2.stb && !bus2.stall)
            q2.push_back(bus2.adr);
         if (q2.size() != 0) begin
            bus2.dat_i <= rom(q2[0]);
            bus2.ack   <= 1'b1;
            void'(q2.pop_front());
         end
      end
   end

   logic [aw-1:0] wpc[$];
   logic [15:0]   wdat[$];

   always @(negedge clk) begin
      if (!rst2 && insn_valid2 && ready2) begin
         wpc.push_back(insn_pc2);
         wdat.push_back(insn2);
      end
   end

   int pass_cnt = 0;
   int total    = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic          stall;
      logic          stb;
      logic [aw-1:0] adr;
      logic          valid;
      logic [aw-1:0] pc;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int acc;
      int hit;
      logic          found;
      logic [aw-1:0] fadr;

      rst        = 1'b1;
      rst2       = 1'b1;
      pc_load    = 1'b0;
      pc_target  = '0;
      ready      = 1'b1;
      ack_en     = 1'b1;
      bus.stall  = 1'b0;
      pc_load2   = 1'b0;
      pc_target2 = '0;
      ready2     = 1'b1;
      bus2.stall = 1'b0;

      tbl[0]  = '{0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 0, 0};
      tbl[2]  = '{0, 1, 1, 0, 0};
      tbl[3]  = '{0, 1, 2, 1, 0};
      tbl[4]  = '{0, 1, 3, 1, 1};
      tbl[5]  = '{0, 1, 4, 1, 2};
      tbl[6]  = '{1, 1, 5, 1, 3};
      tbl[7]  = '{1, 1, 5, 1, 4};
      tbl[8]  = '{1, 1, 5, 0, 0};
      tbl[9]  = '{0, 1, 5, 0, 0};
      tbl[10] = '{0, 1, 6, 0, 0};
      tbl[11] = '{0, 1, 7, 1, 5};
      tbl[12] = '{0, 1, 8, 1, 6};
      tbl[13] = '{0, 1, 9, 1, 7};

      repeat (3) @(negedge clk);
      rst2 = 1'b0;

      // stream from reset, with a 3-cycle stall on adr 5
      reset_dut();
      chk("rst_cyc", 32'(bus.cyc), 0);
      for (int i = 0; i < 14; i++) begin
         bus.stall = tbl[i].stall;
         chk($sformatf("stb[%0d]", i),
             32'(bus.stb), 32'(tbl[i].stb));
         chk($sformatf("adr[%0d]", i),
             32'(bus.adr), 32'(tbl[i].adr));
         chk($sformatf("valid[%0d]", i),
             32'(insn_valid), 32'(tbl[i].valid));
         if (tbl[i].valid) begin
            chk($sformatf("pc[%0d]", i),
                32'(insn_pc), 32'(tbl[i].pc));
            chk($sformatf("insn[%0d]", i),
                32'(insn), 32'(rom(tbl[i].pc)));
         end
         @(negedge clk);
      end
      bus.stall = 1'b0;

      // back-pressure: fill to depth, then drain
      ready = 1'b0;
      reset_dut();
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.stb && !bus.stall)
            acc++;
         @(negedge clk);
      end
      chk("fill_acc", 32'(acc), 4);
      chk("fill_stb", 32'(bus.stb), 0);
      chk("fill_cyc", 32'(bus.cyc), 0);
      chk("fill_cnt", 32'(u_dut.cnt), 4);
      ready = 1'b1;
      found = 1'b0;
      fadr  = '0;
      for (int k = 0; k < 4; k++) begin
         if (bus.stb && !found) begin
            found = 1'b1;
            fadr  = bus.adr;
         end
         chk($sformatf("drain_v[%0d]", k),
             32'(insn_valid), 1);
         chk($sformatf("drain_pc[%0d]", k),
             32'(insn_pc), 32'(k));
         chk($sformatf("drain_insn[%0d]", k),
             32'(insn), 32'(rom(aw'(k))));
         @(negedge clk);
      end
      chk("resume_seen", 32'(found), 1);
      chk("resume_adr", 32'(fadr), 4);

      // redirect with two responses outstanding
      ack_en = 1'b0;
      reset_dut();
      repeat (3) @(negedge clk);
      chk("redir_out", 32'(u_dut.out_cnt), 2);
      pc_load   = 1'b1;
      pc_target = aw'('h100);
      bus.stall = 1'b1;
      ack_en    = 1'b1;
      @(negedge clk);
      pc_load   = 1'b0;
      bus.stall = 1'b0;
      chk("redir_dis", 32'(u_dut.dis_cnt), 2);
      chk("redir_stb", 32'(bus.stb), 0);
      hit = -1;
      for (int i = 0; i < 12; i++) begin
         if (insn_valid && hit < 0) begin
            hit = i;
            chk("redir_pc", 32'(insn_pc), 'h100);
            chk("redir_insn", 32'(insn),
                32'(rom(aw'('h100))));
         end
         if (hit < 0 || i == hit + 1)
            @(negedge clk);
      end
      chk("redir_lat", 32'(hit), 4);
      chk("redir_pc2", 32'(insn_pc), 'h101);

      // reset with 2 outstanding and FIFO half full
      ready  = 1'b0;
      ack_en = 1'b1;
      reset_dut();
      repeat (3) @(negedge clk);
      ack_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_out", 32'(u_dut.out_cnt), 2);
      chk("mid_cnt", 32'(u_dut.cnt), 2);
      chk("mid_stb", 32'(bus.stb), 0);
      rst    = 1'b1;
      ack_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_cyc", 32'(bus.cyc), 0);
      chk("mid_valid", 32'(insn_valid), 0);
      @(negedge clk);
      chk("mid_stb1", 32'(bus.stb), 1);
      chk("mid_adr", 32'(bus.adr), 0);
      chk("mid_v1", 32'(insn_valid), 0);
      @(negedge clk);
      chk("mid_v2", 32'(insn_valid), 0);
      @(negedge clk);
      chk("mid_v3", 32'(insn_valid), 1);
      chk("mid_pc", 32'(insn_pc), 0);
      chk("mid_insn", 32'(insn), 32'(rom('0)));

      // address wrap from reset_pc = 'h1FFE
      chk("wrap_n", 32'(wpc.size() >= 4), 1);
      for (int k = 0; k < 4; k++) begin
         logic [aw-1:0] e;
         e = aw'('h1FFE + k);
         if (k < wpc.size()) begin
            chk($sformatf("wrap_pc[%0d]", k),
                32'(wpc[k]), 32'(e));
            chk($sformatf("wrap_insn[%0d]", k),
                32'(wdat[k]), 32'(rom(e)));
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/wb_ifetch.md
# wb_ifetch

Instruction prefetch unit: Wishbone classic-pipelined master that streams sequential 16-bit instruction words from the program ROM slave into a small prefetch FIFO for the J1 core. It sits directly upstream of the ROM slave, driving its `if_wb.slave` port, and directly downstream of the core's PC logic. A `pc_load` redirect flushes the FIFO and discards all in-flight responses.

## Interface

Parameters:
- `size`, `'h2000`: ROM size in 16-bit words; fetch addresses wrap modulo `size` (power of two).
- `depth`, `4`: prefetch FIFO depth (power of two, ≥2); also the bound on outstanding requests plus buffered words.
- `reset_pc`, `0`: first fetch address after reset.

Ports:
- `wb.clk`  in  1: clock, all logic on rising edge (`if_wb.master wb` bundle).
- `wb.rst`  in  1: synchronous, active-high reset.
- `wb.cyc`, `wb.stb`  out  1: bus cycle / strobe.
- `wb.we`  out  1: tied 0.
- `wb.sel`  out  2: tied `2'b11`.
- `wb.adr`  out  $clog2(size): word address of current request.
- `wb.dat_i`  in  16: read data, valid with `wb.ack`.
- `wb.ack`  in  1: response strobe, one per accepted request, in order.
- `wb.stall`  in  1: request not accepted this cycle.
- `pc_load`  in  1: redirect fetch to `pc_target`.
- `pc_target`  in  $clog2(size): redirect address.
- `insn`  out  16: FIFO head instruction.
- `insn_pc`  out  $clog2(size): address of `insn`.
- `insn_valid`  out  1: FIFO non-empty.
- `insn_ready`  in  1: consumer pops head when `insn_valid & insn_ready`.

## Operation

- State: fetch address `fa`, outstanding count `out_cnt` (0..depth), discard count `dis_cnt` (0..depth), FIFO count `cnt`, FIFO stores {data, pc}.
- Reset: `fa=reset_pc`, all counts 0, FIFO empty; `wb.cyc=0`, `wb.stb=0`, `insn_valid=0`, `wb.adr=reset_pc`.
- Issue: `wb.stb = (cnt + out_cnt < depth) & (dis_cnt == 0)`, from registered state only; `wb.adr = fa`. Request accepted when `stb & ~stall`; then `fa <= fa+1` (wraps `size-1 -> 0`), `out_cnt++`. While stalled, `adr` and `stb` hold.
- `wb.cyc = stb | (out_cnt != 0)`; cyc never drops with responses outstanding.
- Response: on `ack`, `out_cnt--` (net with simultaneous accept). If `dis_cnt != 0`: data dropped, `dis_cnt--`. Otherwise `{dat_i, pc}` pushed; pc comes from a response-address counter that advances per kept ack. No overflow possible under the credit rule.
- Pop: `insn_valid & insn_ready` removes the head. Push and pop in the same cycle: `cnt` unchanged.
- Redirect (`pc_load`, sampled at edge): FIFO emptied and pop ignored; `fa <= pc_target`; response-address counter `<= pc_target`; `dis_cnt <= out_cnt + accept_this_cycle - ack_this_cycle` (an ack in the redirect cycle is dropped). Back-to-back `pc_load`: last one wins; `dis_cnt` is recomputed the same way.
- Reset mid-operation: all state returns to reset values next cycle. Late acks after reset are ignored because `out_cnt=0` and `cyc=0`.

## Timing

- Slave with 1-cycle ack, no stall: redirect sampled in cycle 0 → stb with `adr=T` in cycle 1 → ack cycle 2 → `insn_valid`, `insn=rom[T]`, `insn_pc=T` in cycle 3.
- With zero outstanding at redirect, the redirect-to-valid latency is 3 cycles. Each discarded response adds its drain time, because stb stays low while `dis_cnt != 0`.
- Sustained throughput of 1 word/cycle with `insn_ready` held high and no stall.
- With `insn_ready` low, the FIFO fills and issue stops after `cnt + out_cnt = depth`. At most `depth` words are requested beyond the head.

## Test plan

- Reset release, `reset_pc=0`, ROM `rom[i]=i^16'hA5A5`, ready=1 → adr 0,1,2… from cycle 1, `insn_valid` from cycle 3, `insn`/`insn_pc` = `rom[i]`/`i` in order, one per cycle.
- Hold `insn_ready=0` → exactly 4 requests issued, stb low afterward, `cnt=4`; raise ready → 4 words popped in order, fetching resumes at adr 4.
- `pc_load`, `pc_target='h100`, with 2 requests outstanding → both responses dropped, then `insn_pc='h100` first, no stale words delivered.
- Stall slave 3 cycles on adr 5 → adr/stb held at 5, then 5,6,7 delivered with no gap or duplicate.
- `reset_pc='h1FFE` → pcs `'h1FFE, 'h1FFF, 0, 1` (address wrap).
- Assert `wb.rst` with 2 outstanding and FIFO half full → next cycle `cyc=0`, `insn_valid=0`, first fetch at `reset_pc`.
